// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared constants for the button conditioner
package button_conditioner_pkg;

  localparam int N_BTN          = 7;
  localparam int BTN_RIGHT      = 0;
  localparam int BTN_LEFT       = 1;
  localparam int BTN_DOWN       = 2;
  localparam int BTN_UP         = 3;
  localparam int BTN_DECISION   = 4;
  localparam int BTN_RESET_RED  = 5;
  localparam int BTN_RESET_BLUE = 6;

  localparam int DB_CYCLES_DEF  = 500000;

  // One-hot of the highest set bit (bit BTN_RESET_BLUE wins), zero if none set.
  function automatic logic [N_BTN-1:0] top_onehot(input logic [N_BTN-1:0] v);
    logic [N_BTN-1:0] r;
    r = '0;
    for (int i = BTN_RIGHT; i <= BTN_RESET_BLUE; i++) begin
      if (v[i]) r = N_BTN'(1) << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser, debounce counter and rise detect
module debounce_bit
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff  = (r_sync2 != r_level);
  assign w_done  = w_diff && (r_cnt == LP_LAST);
  // Rise is flagged combinationally so pending captures it on the toggle edge.
  assign o_rise  = w_done & r_sync2;
  assign o_level = r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces 7 buttons and serialises presses
// into at most one single-cycle pulse per clock, highest bit first.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int CNT_W      = $clog2(DB_CYCLES),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic             pend_any
);

  logic [N_BTN-1:0] w_norm;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_issue;
  logic [N_BTN-1:0] w_pending_nxt;
  logic [N_BTN-1:0] r_pending;
  logic [N_BTN-1:0] r_pulse;
  logic             r_pend_any;

  assign w_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_din   (w_norm[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // A rise on the bit being issued re-arms it, so a fast re-press is not lost.
  assign w_issue       = top_onehot(r_pending);
  assign w_pending_nxt = (r_pending & ~w_issue) | w_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_pulse    <= '0;
      r_pend_any <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_pulse    <= w_issue;
      r_pend_any <= |w_pending_nxt;
    end
  end

  assign btn_pulse = r_pulse;
  assign btn_level = w_level;
  assign pend_any  = r_pend_any;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench with reference model
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] raw_m = 7'h00, raw_a = 7'h7F, raw_d = 7'h00;
  logic [6:0] pulse_m, level_m, pulse_a, level_a, pulse_d, level_d;
  logic       pany_m, pany_a, pany_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DB_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_main (
    .clk(clk), .rst(rst), .btn_raw(raw_m),
    .btn_pulse(pulse_m), .btn_level(level_m), .pend_any(pany_m));

  button_conditioner #(.DB_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_a),
    .btn_pulse(pulse_a), .btn_level(level_a), .pend_any(pany_a));

  button_conditioner #(.DB_CYCLES(2), .ACTIVE_LOW(1'b0)) dut_db2 (
    .clk(clk), .rst(rst), .btn_raw(raw_d),
    .btn_pulse(pulse_d), .btn_level(level_d), .pend_any(pany_d));

  // Reference model state, one slot per instance: 0 main, 1 active-low, 2 short debounce.
  int         db_c [3] = '{4, 4, 2};
  bit         al_c [3] = '{1'b0, 1'b1, 1'b0};
  logic [6:0] hist [3][2];
  logic [6:0] md_lvl [3];
  logic [6:0] md_pend [3];
  logic [6:0] md_pulse [3];
  bit         md_pany [3];
  int         md_run [3][7];

  function automatic logic [6:0] raw_of(int j);
    case (j)
      0: return raw_m;
      1: return raw_a;
      default: return raw_d;
    endcase
  endfunction

  function automatic logic [6:0] pulse_of(int j);
    case (j)
      0: return pulse_m;
      1: return pulse_a;
      default: return pulse_d;
    endcase
  endfunction

  function automatic logic [6:0] level_of(int j);
    case (j)
      0: return level_m;
      1: return level_a;
      default: return level_d;
    endcase
  endfunction

  function automatic logic pany_of(int j);
    case (j)
      0: return pany_m;
      1: return pany_a;
      default: return pany_d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model: stable-run counting per button, then a
  // highest-index-first queue of accepted presses.
  task automatic model_edge();
    for (int j = 0; j < 3; j++) begin
      logic [6:0] n, rise, pick;
      if (rst) begin
        hist[j][0] = '0; hist[j][1] = '0;
        md_lvl[j] = '0; md_pend[j] = '0; md_pulse[j] = '0; md_pany[j] = 1'b0;
        for (int b = 0; b < 7; b++) md_run[j][b] = 0;
      end else begin
        n = al_c[j] ? ~raw_of(j) : raw_of(j);
        rise = '0;
        for (int b = 0; b < 7; b++) begin
          if (hist[j][1][b] != md_lvl[j][b]) begin
            md_run[j][b] = md_run[j][b] + 1;
            if (md_run[j][b] >= db_c[j]) begin
              md_lvl[j][b] = hist[j][1][b];
              md_run[j][b] = 0;
              if (hist[j][1][b]) rise[b] = 1'b1;
            end
          end else begin
            md_run[j][b] = 0;
          end
        end
        pick = '0;
        for (int b = 6; b >= 0; b--) if (md_pend[j][b] && pick == 0) pick[b] = 1'b1;
        md_pulse[j] = pick;
        md_pend[j]  = (md_pend[j] & ~pick) | rise;
        md_pany[j]  = |md_pend[j];
        hist[j][1]  = hist[j][0];
        hist[j][0]  = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("model_pulse[%0d]", j), {1'b0, pulse_of(j)}, {1'b0, md_pulse[j]});
      chk($sformatf("model_level[%0d]", j), {1'b0, level_of(j)}, {1'b0, md_lvl[j]});
      chk($sformatf("model_pany[%0d]", j), {7'b0, pany_of(j)}, {7'b0, md_pany[j]});
      chk($sformatf("onehot[%0d]", j), {7'b0, $countones(pulse_of(j)) <= 1}, 8'h01);
    end
  endtask

  task automatic idle(input int n);
    raw_m = 7'h00; raw_a = 7'h7F; raw_d = 7'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold;
    int npulse;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("rst_pulse", {1'b0, pulse_m}, 8'h00);
    chk("rst_level", {1'b0, level_m}, 8'h00);
    chk("rst_pany", {7'b0, pany_m}, 8'h00);
    rst = 1'b0;
    idle(4);

    // 1: single press of right
    raw_m = 7'h01;
    for (int e = 1; e <= 5; e++) tick();
    chk("t1_level_e5", {1'b0, level_m}, 8'h00);
    tick();
    chk("t1_level_e6", {1'b0, level_m}, 8'h01);
    chk("t1_pulse_e6", {1'b0, pulse_m}, 8'h00);
    tick();
    chk("t1_pulse_e7", {1'b0, pulse_m}, 8'h01);
    for (int e = 8; e <= 14; e++) begin
      tick();
      chk("t1_pulse_held", {1'b0, pulse_m}, 8'h00);
    end
    raw_m = 7'h00;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("t1_pulse_rel", {1'b0, pulse_m}, 8'h00);
    end
    chk("t1_level_rel", {1'b0, level_m}, 8'h00);

    // 2: bounce shorter than the debounce window
    for (int c = 0; c < 20; c++) begin
      raw_m = ((c / 2) % 2 == 0) ? 7'h01 : 7'h00;
      tick();
      chk("t2_level", {1'b0, level_m}, 8'h00);
      chk("t2_pulse", {1'b0, pulse_m}, 8'h00);
    end
    idle(12);

    // 3: simultaneous up, decision, right
    raw_m = 7'h19;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("t3_pulse_early", {1'b0, pulse_m}, 8'h00);
    end
    tick();
    chk("t3_pulse_e7", {1'b0, pulse_m}, 8'h10);
    chk("t3_pany_e7", {7'b0, pany_m}, 8'h01);
    tick();
    chk("t3_pulse_e8", {1'b0, pulse_m}, 8'h08);
    chk("t3_pany_e8", {7'b0, pany_m}, 8'h01);
    tick();
    chk("t3_pulse_e9", {1'b0, pulse_m}, 8'h01);
    chk("t3_pany_e9", {7'b0, pany_m}, 8'h00);
    tick();
    chk("t3_pulse_e10", {1'b0, pulse_m}, 8'h00);
    idle(12);

    // 4: left re-rises on the edge it is issued (short-debounce instance)
    raw_d = 7'h72;
    tick(); tick();
    raw_d = 7'h70;
    tick(); tick();
    raw_d = 7'h72;
    tick(); chk("t4_pulse_e5", {1'b0, pulse_d}, 8'h40);
    tick(); chk("t4_pulse_e6", {1'b0, pulse_d}, 8'h20);
    tick(); chk("t4_pulse_e7", {1'b0, pulse_d}, 8'h10);
    tick(); chk("t4_pulse_e8", {1'b0, pulse_d}, 8'h02);
    tick(); chk("t4_pulse_e9", {1'b0, pulse_d}, 8'h02);
    tick(); chk("t4_pulse_e10", {1'b0, pulse_d}, 8'h00);
    idle(12);

    // 5: async reset with down pending and up mid-count; down held through reset
    raw_m = 7'h04;
    tick(); tick();
    raw_m = 7'h0C;
    for (int e = 3; e <= 6; e++) tick();
    chk("t5_pany_before", {7'b0, pany_m}, 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_pulse", {1'b0, pulse_m}, 8'h00);
    chk("t5_async_level", {1'b0, level_m}, 8'h00);
    chk("t5_async_pany", {7'b0, pany_m}, 8'h00);
    raw_m = 7'h04;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("t5_pulse_early", {1'b0, pulse_m}, 8'h00);
    end
    tick();
    chk("t5_pulse_e7", {1'b0, pulse_m}, 8'h04);
    tick();
    chk("t5_pulse_e8", {1'b0, pulse_m}, 8'h00);
    idle(12);

    // 6: active-low board, press reset_blue
    raw_a = 7'h3F;
    for (int e = 1; e <= 6; e++) tick();
    tick();
    chk("t6_pulse_e7", {1'b0, pulse_a}, 8'h40);
    npulse = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (pulse_a != 0) npulse++;
    end
    raw_a = 7'h7F;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (pulse_a != 0) npulse++;
    end
    chk("t6_extra_pulses", 8'(npulse), 8'h00);

    // Random stimulus against the model
    for (int seg = 0; seg < 40; seg++) begin
      raw_m = 7'($urandom) & 7'($urandom);
      raw_a = 7'($urandom) | 7'($urandom);
      raw_d = 7'($urandom);
      hold = $urandom_range(1, 10);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      for (int i = 0; i < hold; i++) tick();
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
